cpu_seq: RTL and testbench
==========================

Name: cpu_seq

Overview:
Parametrised fetch/execute sequencer for the teaching CPU. It owns the stage FSM, the program counter, and the opcode/operand instruction registers. It drives all control and address muxing to the external RAM, register file and ALU. It generalises the fixed 8-bit core to configurable data, address and register-select widths, and adds ST/ADD/SUB/JMP/JZ/HLT execution, a latched halt request and PC load.

Parameters:
DATA_W, 8, instruction/data word width; must be >= 5+REG_SEL_W and >= 2*REG_SEL_W
ADDR_W, 8, RAM address and PC width; must be <= DATA_W (operand is the jump target)
REG_SEL_W, 3, register-file select width (2^REG_SEL_W registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  start request, sampled in AWAIT
halt  in  1  stop request, latched in any non-AWAIT stage
ram_rdata  in  DATA_W  RAM read data, valid within the cycle its address is presented
rf_aout  in  DATA_W  register-file port A data
rf_bout  in  DATA_W  register-file port B data
alu_sout  in  DATA_W  registered ALU result
alu_zflag  in  1  registered ALU zero flag
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rden  out  1  RAM read enable
ram_wren  out  1  RAM write enable
rf_asel  out  REG_SEL_W  register-file port A select
rf_bsel  out  REG_SEL_W  register-file port B select
rf_csel  out  REG_SEL_W  register-file write select
rf_cin  out  DATA_W  register-file write data
rf_cload  out  1  register-file write strobe
alu_ena  out  1  ALU capture enable
alu_ctrl  out  2  ALU operation: 00 add, 01 sub
await, fetcha, fetchb, execa, execb  out  1 each  one-hot stage flags
pc_out  out  ADDR_W  program counter
opecode, operand  out  DATA_W each  instruction registers
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst=0, async): stage AWAIT; pc, opecode, operand, the memory data register (mdr) and the halt request are 0; illegal=0. All strobes are 0.
- Stage FSM:
  - AWAIT -> FETCHA when run=1 and halt=0. With run=halt=1 the FSM stays in AWAIT.
  - FETCHA -> FETCHB -> EXECA -> EXECB.
  - EXECB -> AWAIT if the halt request is latched, halt=1 now, or the opcode is HLT; otherwise EXECB -> FETCHA.
  - The halt request clears on entering AWAIT.
- FETCHA: ram_addr=pc, ram_rden=1, opecode<=ram_rdata, pc<=pc+1.
- FETCHB: same sequence as FETCHA, but loads operand instead of opecode.
- PC arithmetic is modulo 2^ADDR_W: all-ones+1 wraps to 0.
- Opcode class is opecode[DATA_W-1 -: 5]; c = opecode[REG_SEL_W-1:0].
- Operand register fields: ra = operand[DATA_W-1 -: REG_SEL_W]; rb = the next REG_SEL_W bits below ra.
- Default outputs: rf_asel=ra, rf_bsel=rb, rf_csel=c. ram_rden=1 and ram_addr=0 in EXECA/EXECB unless an instruction below overrides them.
- NOP 00000: no action.
- MOV 00001: EXECB rf_cload=1, rf_cin=rf_aout.
- LD 01000:
  - EXECA: ram_addr=rf_aout[ADDR_W-1:0], mdr<=ram_rdata.
  - EXECB: rf_cload=1, rf_cin=mdr.
- LDI 01010: EXECB rf_cload=1, rf_cin=operand.
- ST 01100: EXECA rf_bsel=c, ram_addr=rf_aout, ram_wdata=rf_bout, ram_wren=1, ram_rden=0.
- ADD 10000 / SUB 10001:
  - EXECA: alu_ena=1, alu_ctrl=00 or 01.
  - EXECB: rf_cload=1, rf_cin=alu_sout.
- JMP 11000: at the EXECB edge, pc<=operand[ADDR_W-1:0].
- JZ 11001: same as JMP, only if alu_zflag=1 in EXECB.
- HLT 11111: no datapath action; returns to AWAIT.
- ram_wren and ram_rden are never both 1.
- rf_cload and alu_ena are asserted only in the stated stages.
- Undefined classes are treated as NOP unless the optional feature is enabled.
- Reset mid-instruction abandons the instruction; no partial writes occur after rst falls.

Optional Feature:
CPU_SEQ_ILLEGAL_TRAP_EN:
- Defined: an undefined opcode class sets illegal at the EXECB edge and forces EXECB -> AWAIT. illegal clears only on reset.
- Undefined: undefined classes execute as NOP and illegal is tied to 0.

Decomposition:
- Package cpu_pkg: 5-bit opcode class constants (NOP, MOV, LD, LDI, ST, ADD, SUB, JMP, JZ, HLT), ALU ctrl constants, stage encoding enum.
- Natural sub-module: cpu_seq_stage (the stage FSM with the halt-request latch), exporting the one-hot flags.
- The PC, IR and control decode stay in cpu_seq.

Test Plan:
- Reset, then run pulse with RAM[0..1]=0x51,0x2A (LDI r1,0x2A) -> fetcha, fetchb, execa, execb in consecutive cycles; in EXECB rf_cload=1, rf_csel=1, rf_cin=0x2A; pc_out=2.
- RAM[0..1]=0x42,0x20 (LD r2,(r1)), rf_aout=0x30, RAM[0x30]=0x77 -> EXECA ram_addr=0x30; EXECB rf_cin=0x77, rf_csel=2.
- 0x83,0x28 (ADD r3=r1+r2) -> EXECA alu_ena=1, alu_ctrl=00, rf_asel=1, rf_bsel=2; EXECB rf_cload=1, rf_cin=alu_sout.
- Control flow:
  - 0xC0,0x10 (JMP 0x10) -> next fetcha with ram_addr=0x10.
  - 0xC8,0x10 (JZ) with alu_zflag=0 -> pc continues at 2.
  - pc=0xFE with fetch -> pc wraps to 0x00.
- Halt handling:
  - halt pulsed during FETCHB -> the instruction completes, then await=1.
  - Opcode 0xF8 (HLT) -> await after EXECB.
  - run=halt=1 in AWAIT -> stays in AWAIT.
- rst low during EXECA of ST -> ram_wren drops immediately and stage=AWAIT. Opcode 0x38 with CPU_SEQ_ILLEGAL_TRAP_EN -> illegal=1 and AWAIT; without the macro -> NOP and execution continues.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the teaching-CPU sequencer.
//   - 5-bit opcode class constants (opecode[DATA_W-1 -: 5])
//   - ALU control constants
//   - stage_t: sequencer stage encoding
//   - op_defined(): true for the opcode classes the sequencer executes
package cpu_pkg;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_MOV = 5'b00001;
    localparam logic [4:0] OP_LD  = 5'b01000;
    localparam logic [4:0] OP_LDI = 5'b01010;
    localparam logic [4:0] OP_ST  = 5'b01100;
    localparam logic [4:0] OP_ADD = 5'b10000;
    localparam logic [4:0] OP_SUB = 5'b10001;
    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_JZ  = 5'b11001;
    localparam logic [4:0] OP_HLT = 5'b11111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef enum logic [2:0] {
        STG_AWAIT,
        STG_FETCHA,
        STG_FETCHB,
        STG_EXECA,
        STG_EXECB
    } stage_t;

    function automatic logic op_defined(input logic [4:0] cls);
        case (cls)
            OP_NOP, OP_MOV, OP_LD, OP_LDI, OP_ST,
            OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_HLT: op_defined = 1'b1;
            default:                               op_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_seq_stage.sv
// cpu_seq_stage: stage FSM of the sequencer with the halt-request latch.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   run            start request, sampled in AWAIT (ignored while halt=1)
//   halt           stop request, latched in any non-AWAIT stage
//   stop           current instruction ends the program (HLT / trap)
//   stage          current stage, for decode in the parent
//   await..execb   one-hot stage flags
module cpu_seq_stage
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   run,
    input  logic   halt,
    input  logic   stop,
    output stage_t stage,
    output logic   await,
    output logic   fetcha,
    output logic   fetchb,
    output logic   execa,
    output logic   execb
);

    stage_t state, state_nx;
    logic   halt_req, halt_req_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= STG_AWAIT;
            halt_req <= 1'b0;
        end else begin
            state    <= state_nx;
            halt_req <= halt_req_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        halt_req_nx = halt_req;
        case (state)
            STG_AWAIT: begin
                halt_req_nx = 1'b0;
                if (run && !halt) state_nx = STG_FETCHA;
            end
            STG_FETCHA: begin
                halt_req_nx = halt_req | halt;
                state_nx    = STG_FETCHB;
            end
            STG_FETCHB: begin
                halt_req_nx = halt_req | halt;
                state_nx    = STG_EXECA;
            end
            STG_EXECA: begin
                halt_req_nx = halt_req | halt;
                state_nx    = STG_EXECB;
            end
            STG_EXECB: begin
                // Either leaving for AWAIT (request cleared) or no request pending.
                halt_req_nx = 1'b0;
                if (halt_req || halt || stop) state_nx = STG_AWAIT;
                else                          state_nx = STG_FETCHA;
            end
            default: begin
                halt_req_nx = 1'b0;
                state_nx    = STG_AWAIT;
            end
        endcase
    end

    assign stage  = state;
    assign await  = (state == STG_AWAIT);
    assign fetcha = (state == STG_FETCHA);
    assign fetchb = (state == STG_FETCHB);
    assign execa  = (state == STG_EXECA);
    assign execb  = (state == STG_EXECB);

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: fetch/execute sequencer of the teaching CPU.
// Owns the PC, the opcode/operand instruction registers and the memory data
// register, and drives RAM, register-file and ALU control.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   run, halt                start / stop requests
//   ram_rdata                RAM read data (combinational w.r.t. ram_addr)
//   rf_aout, rf_bout         register-file read ports
//   alu_sout, alu_zflag      registered ALU result and zero flag
//   ram_addr/wdata/rden/wren RAM interface
//   rf_asel/bsel/csel/cin/cload  register-file interface
//   alu_ena, alu_ctrl        ALU capture enable and operation
//   await..execb             one-hot stage flags
//   pc_out, opecode, operand program counter and instruction registers
//   illegal                  sticky illegal-opcode flag
// Build option: CPU_SEQ_ILLEGAL_TRAP_EN -- undefined opcode classes set
// illegal and return to AWAIT; otherwise they execute as NOP and illegal=0.
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int REG_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 halt,
    input  logic [DATA_W-1:0]    ram_rdata,
    input  logic [DATA_W-1:0]    rf_aout,
    input  logic [DATA_W-1:0]    rf_bout,
    input  logic [DATA_W-1:0]    alu_sout,
    input  logic                 alu_zflag,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    output logic                 ram_rden,
    output logic                 ram_wren,
    output logic [REG_SEL_W-1:0] rf_asel,
    output logic [REG_SEL_W-1:0] rf_bsel,
    output logic [REG_SEL_W-1:0] rf_csel,
    output logic [DATA_W-1:0]    rf_cin,
    output logic                 rf_cload,
    output logic                 alu_ena,
    output logic [1:0]           alu_ctrl,
    output logic                 await,
    output logic                 fetcha,
    output logic                 fetchb,
    output logic                 execa,
    output logic                 execb,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [DATA_W-1:0]    opecode,
    output logic [DATA_W-1:0]    operand,
    output logic                 illegal
);

    stage_t               stage;
    logic [ADDR_W-1:0]    pc;
    logic [DATA_W-1:0]    mdr;
    logic [4:0]           cls;
    logic [REG_SEL_W-1:0] c_sel, ra_sel, rb_sel;
    logic                 stop;

    assign cls    = opecode[DATA_W-1 -: 5];
    assign c_sel  = opecode[REG_SEL_W-1:0];
    assign ra_sel = operand[DATA_W-1 -: REG_SEL_W];
    assign rb_sel = operand[DATA_W-1-REG_SEL_W -: REG_SEL_W];

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign stop    = (cls == OP_HLT) || !op_defined(cls);
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        illegal_q <= 1'b0;
        else if (stage == STG_EXECB && !op_defined(cls)) illegal_q <= 1'b1;
    end
`else
    assign stop    = (cls == OP_HLT);
    assign illegal = 1'b0;
`endif

    cpu_seq_stage u_stage (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .halt   (halt),
        .stop   (stop),
        .stage  (stage),
        .await  (await),
        .fetcha (fetcha),
        .fetchb (fetchb),
        .execa  (execa),
        .execb  (execb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            opecode <= '0;
            operand <= '0;
            mdr     <= '0;
        end else begin
            case (stage)
                STG_FETCHA: begin
                    opecode <= ram_rdata;
                    pc      <= pc + ADDR_W'(1);
                end
                STG_FETCHB: begin
                    operand <= ram_rdata;
                    pc      <= pc + ADDR_W'(1);
                end
                STG_EXECA: begin
                    if (cls == OP_LD) mdr <= ram_rdata;
                end
                STG_EXECB: begin
                    if (cls == OP_JMP || (cls == OP_JZ && alu_zflag))
                        pc <= operand[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign pc_out = pc;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_rden  = 1'b0;
        ram_wren  = 1'b0;
        rf_asel   = ra_sel;
        rf_bsel   = rb_sel;
        rf_csel   = c_sel;
        rf_cin    = '0;
        rf_cload  = 1'b0;
        alu_ena   = 1'b0;
        alu_ctrl  = ALU_ADD;
        case (stage)
            STG_FETCHA, STG_FETCHB: begin
                ram_addr = pc;
                ram_rden = 1'b1;
            end
            STG_EXECA: begin
                ram_rden = 1'b1;
                case (cls)
                    OP_LD: ram_addr = rf_aout[ADDR_W-1:0];
                    OP_ST: begin
                        rf_bsel   = c_sel;
                        ram_addr  = rf_aout[ADDR_W-1:0];
                        ram_wdata = rf_bout;
                        ram_wren  = 1'b1;
                        ram_rden  = 1'b0;
                    end
                    OP_ADD: alu_ena = 1'b1;
                    OP_SUB: begin
                        alu_ena  = 1'b1;
                        alu_ctrl = ALU_SUB;
                    end
                    default: ;
                endcase
            end
            STG_EXECB: begin
                ram_rden = 1'b1;
                case (cls)
                    OP_MOV: begin
                        rf_cload = 1'b1;
                        rf_cin   = rf_aout;
                    end
                    OP_LD: begin
                        rf_cload = 1'b1;
                        rf_cin   = mdr;
                    end
                    OP_LDI: begin
                        rf_cload = 1'b1;
                        rf_cin   = operand;
                    end
                    OP_ADD, OP_SUB: begin
                        rf_cload = 1'b1;
                        rf_cin   = alu_sout;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: self-checking bench for cpu_seq (default 8/8/3 configuration).
// A table of single-instruction vectors is run from reset; per-stage
// expectations are queued when stimulus is applied and popped each cycle.
// Hand-written sequences cover run+halt in AWAIT, halt during FETCHB,
// PC wrap and reset during a store.
module tb_cpu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] ram_rdata, rf_aout, rf_bout, alu_sout;
    logic       alu_zflag;
    logic [7:0] ram_addr, ram_wdata, rf_cin, pc_out, opecode, operand;
    logic       ram_rden, ram_wren, rf_cload, alu_ena, illegal;
    logic [2:0] rf_asel, rf_bsel, rf_csel;
    logic [1:0] alu_ctrl;
    logic       await, fetcha, fetchb, execa, execb;

    logic [7:0] ram [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_wren) ram[ram_addr] <= ram_wdata;

    cpu_seq #(.DATA_W(8), .ADDR_W(8), .REG_SEL_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .ram_rdata(ram_rdata), .rf_aout(rf_aout), .rf_bout(rf_bout),
        .alu_sout(alu_sout), .alu_zflag(alu_zflag),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .rf_asel(rf_asel), .rf_bsel(rf_bsel), .rf_csel(rf_csel), .rf_cin(rf_cin),
        .rf_cload(rf_cload), .alu_ena(alu_ena), .alu_ctrl(alu_ctrl),
        .await(await), .fetcha(fetcha), .fetchb(fetchb), .execa(execa), .execb(execb),
        .pc_out(pc_out), .opecode(opecode), .operand(operand), .illegal(illegal)
    );

    typedef struct {
        logic [7:0] opc, opr, rfa, rfb, alus;
        logic       aluz;
        logic [7:0] ea_addr;
        logic       ea_wren, ea_ena;
        logic [1:0] ea_ctrl;
        logic [2:0] ea_bsel;
        logic       eb_cload;
        logic [7:0] eb_cin;
        logic [2:0] eb_csel;
        logic       nx_await;
        logic [7:0] nx_pc;
        logic       nx_ill;
    } vec_t;

    typedef struct {
        string      tag;
        logic [4:0] flags;
        logic       care_addr;
        logic [7:0] addr;
        logic       rden, wren, ena;
        logic [1:0] ctrl;
        logic       cload;
        logic [7:0] cin;
        logic [2:0] csel;
        logic       care_sel;
        logic [2:0] asel, bsel;
        logic [7:0] pc;
        logic       ill;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];

    function automatic exp_t mk(string tag, logic [4:0] flags, logic care_addr, logic [7:0] addr,
                                logic rden, logic wren, logic ena, logic [1:0] ctrl,
                                logic cload, logic [7:0] cin, logic [2:0] csel,
                                logic care_sel, logic [2:0] asel, logic [2:0] bsel,
                                logic [7:0] pc, logic ill);
        exp_t e;
        e.tag = tag; e.flags = flags; e.care_addr = care_addr; e.addr = addr;
        e.rden = rden; e.wren = wren; e.ena = ena; e.ctrl = ctrl;
        e.cload = cload; e.cin = cin; e.csel = csel;
        e.care_sel = care_sel; e.asel = asel; e.bsel = bsel; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        logic [4:0] fl;
        bit ok;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: DUT cycle with no queued expectation");
            return;
        end
        e  = sb.pop_front();
        fl = {await, fetcha, fetchb, execa, execb};
        ok = (fl === e.flags) && (!e.care_addr || ram_addr === e.addr)
             && (ram_rden === e.rden) && (ram_wren === e.wren) && (alu_ena === e.ena)
             && (!e.ena || alu_ctrl === e.ctrl) && (rf_cload === e.cload)
             && (!e.cload || (rf_cin === e.cin && rf_csel === e.csel))
             && (!e.care_sel || (rf_asel === e.asel && rf_bsel === e.bsel))
             && (pc_out === e.pc) && (illegal === e.ill);
        if (!ok) begin
            fails++;
            $display("FAIL %s: got flags=%b addr=%h rden=%b wren=%b ena=%b ctrl=%b cload=%b cin=%h csel=%0d asel=%0d bsel=%0d pc=%h ill=%b; expected flags=%b addr=%h rden=%b wren=%b ena=%b ctrl=%b cload=%b cin=%h csel=%0d asel=%0d bsel=%0d pc=%h ill=%b",
                     e.tag, fl, ram_addr, ram_rden, ram_wren, alu_ena, alu_ctrl, rf_cload, rf_cin,
                     rf_csel, rf_asel, rf_bsel, pc_out, illegal,
                     e.flags, e.addr, e.rden, e.wren, e.ena, e.ctrl, e.cload, e.cin,
                     e.csel, e.asel, e.bsel, e.pc, e.ill);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0; run = 1'b0; halt = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    // Runs one instruction from pc=0; hm pulses halt during FETCHB.
    task automatic run_vec(input int unsigned idx, input bit hm);
        vec_t v;
        string p;
        v = vecs[idx];
        p = $sformatf("v%0d%s", idx, hm ? "_halt" : "");
        do_reset();
        ram[0] = v.opc; ram[1] = v.opr;
        rf_aout = v.rfa; rf_bout = v.rfb; alu_sout = v.alus; alu_zflag = v.aluz;
        sb.push_back(mk({p, "_fetcha"}, 5'b01000, 1, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 3'd0, 0, 3'd0, 3'd0, 8'h00, 0));
        sb.push_back(mk({p, "_fetchb"}, 5'b00100, 1, 8'h01, 1, 0, 0, 2'b00, 0, 8'h00, 3'd0, 0, 3'd0, 3'd0, 8'h01, 0));
        sb.push_back(mk({p, "_execa"}, 5'b00010, 1, v.ea_addr, !v.ea_wren, v.ea_wren, v.ea_ena, v.ea_ctrl,
                        0, 8'h00, 3'd0, 1, v.opr[7:5], v.ea_bsel, 8'h02, 0));
        sb.push_back(mk({p, "_execb"}, 5'b00001, 1, 8'h00, 1, 0, 0, 2'b00, v.eb_cload, v.eb_cin, v.eb_csel,
                        1, v.opr[7:5], v.opr[4:2], 8'h02, 0));
        if (hm || v.nx_await)
            sb.push_back(mk({p, "_next"}, 5'b10000, 0, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00, 3'd0, 0, 3'd0, 3'd0, 8'h02, hm ? 1'b0 : v.nx_ill));
        else
            sb.push_back(mk({p, "_next"}, 5'b01000, 1, v.nx_pc, 1, 0, 0, 2'b00, 0, 8'h00, 3'd0, 0, 3'd0, 3'd0, v.nx_pc, 0));
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            run  = 1'b0;
            halt = hm && (k == 1);
            @(negedge clk);
            check_pop();
        end
        halt = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rf_aout = 8'h00; rf_bout = 8'h00; alu_sout = 8'h00; alu_zflag = 1'b0;

        //          opc    opr    rfa    rfb    alus  z  ea_addr w  e  ctrl  bsel cl  cin    csel aw  nx_pc  ill
        vecs[0]  = '{8'h51, 8'h2A, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd2, 1, 8'h2A, 3'd1, 0, 8'h02, 0}; // LDI r1
        vecs[1]  = '{8'h42, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h30, 0, 0, 2'b00, 3'd0, 1, 8'h77, 3'd2, 0, 8'h02, 0}; // LD r2,(r1)
        vecs[2]  = '{8'h83, 8'h28, 8'h00, 8'h00, 8'h5C, 0, 8'h00, 0, 1, 2'b00, 3'd2, 1, 8'h5C, 3'd3, 0, 8'h02, 0}; // ADD r3
        vecs[3]  = '{8'h8C, 8'h28, 8'h00, 8'h00, 8'h11, 0, 8'h00, 0, 1, 2'b01, 3'd2, 1, 8'h11, 3'd4, 0, 8'h02, 0}; // SUB r4
        vecs[4]  = '{8'h0D, 8'h40, 8'h99, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd0, 1, 8'h99, 3'd5, 0, 8'h02, 0}; // MOV r5
        vecs[5]  = '{8'h66, 8'h20, 8'h40, 8'hAB, 8'h00, 0, 8'h40, 1, 0, 2'b00, 3'd6, 0, 8'h00, 3'd0, 0, 8'h02, 0}; // ST r6,(r1)
        vecs[6]  = '{8'hC0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd4, 0, 8'h00, 3'd0, 0, 8'h10, 0}; // JMP
        vecs[7]  = '{8'hC8, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd4, 0, 8'h00, 3'd0, 0, 8'h02, 0}; // JZ not taken
        vecs[8]  = '{8'hC8, 8'h10, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 0, 2'b00, 3'd4, 0, 8'h00, 3'd0, 0, 8'h10, 0}; // JZ taken
        vecs[9]  = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd0, 0, 8'h00, 3'd0, 1, 8'h02, 0}; // HLT
        vecs[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd0, 0, 8'h00, 3'd0, 0, 8'h02, 0}; // NOP
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        vecs[11] = '{8'h38, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd0, 0, 8'h00, 3'd0, 1, 8'h02, 1}; // trap
`else
        vecs[11] = '{8'h38, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 2'b00, 3'd0, 0, 8'h00, 3'd0, 0, 8'h02, 0}; // as NOP
`endif
        ram[8'h30] = 8'h77;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_state",
                  {27'd0, await, fetcha, fetchb, execa, execb},
                  {27'd0, 5'b10000});
        check_val("reset_regs", {pc_out, opecode, operand, 8'h00},
                  32'h0000_0000);
        check_val("reset_strobes", {27'd0, illegal, ram_rden, ram_wren, rf_cload, alu_ena},
                  32'd0);
        #1 rst = 1'b1;

        // run=halt=1 in AWAIT holds the FSM
        @(posedge clk); #1 run = 1'b1; halt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("run_and_halt_await", {31'd0, await}, 32'd1);
        run = 1'b0; halt = 1'b0;

        // Table-driven instruction vectors
        for (int unsigned i = 0; i < 12; i++) begin
            if (i == 5) ram[8'h40] = 8'h00;
            run_vec(i, 1'b0);
            if (i == 5) check_val("st_ram_write", {24'd0, ram[8'h40]}, 32'h0000_00AB);
        end

        // halt during FETCHB: instruction completes, then AWAIT
        run_vec(0, 1'b1);

        // PC wrap: JMP 0xFE, then fetch at 0xFE / 0xFF
        do_reset();
        ram[0] = 8'hC0; ram[1] = 8'hFE; ram[8'hFE] = 8'h00; ram[8'hFF] = 8'h00;
        alu_zflag = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 run = 1'b0;
        end
        @(negedge clk);
        check_val("wrap_fetcha_pc", {23'd0, fetcha, pc_out}, {23'd0, 1'b1, 8'hFE});
        @(posedge clk); @(negedge clk);
        check_val("wrap_fetchb_pc", {23'd0, fetchb, pc_out}, {23'd0, 1'b1, 8'hFF});
        @(posedge clk); @(negedge clk);
        check_val("wrap_execa_pc", {23'd0, execa, pc_out}, {23'd0, 1'b1, 8'h00});

        // Reset falls during EXECA of ST: write strobe drops at once, no write
        do_reset();
        ram[0] = 8'h66; ram[1] = 8'h20; ram[8'h40] = 8'h00;
        rf_aout = 8'h40; rf_bout = 8'hAB;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 run = 1'b0;
        end
        @(negedge clk);
        check_val("st_execa_wren", {30'd0, execa, ram_wren}, 32'd3);
        rst = 1'b0;
        #1;
        check_val("rst_mid_st", {29'd0, ram_wren, await, execa}, 32'b010);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_st_no_write", {23'd0, await, ram[8'h40]}, {23'd0, 1'b1, 8'h00});

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
